// File: rtl/taylor_pkg.sv
// Shared types and helpers for the bfloat16 Taylor-datapath output stage.
//   rnd_mode_t          : IEEE rounding modes as carried on rndMode_i
//   FLAG_*              : bit positions inside the sticky flag vector
//   PLUS_INF_BF16       : +infinity encoding (sign bit ORed in by the user)
//   MAX_FIN_BF16        : +largest finite encoding
//   FUNC_rndInc         : round-up decision for a given mode and G/R/S
package taylor_pkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RDN = 2'd2,
    RND_RUP = 2'd3
  } rnd_mode_t;

  localparam int FLAG_NX   = 0;
  localparam int FLAG_UF   = 1;
  localparam int FLAG_OF   = 2;
  localparam int FLAG_DROP = 3;

  localparam logic [15:0] PLUS_INF_BF16 = 16'h7F80;
  localparam logic [15:0] MAX_FIN_BF16  = 16'h7F7F;

  function automatic logic FUNC_rndInc(input logic      s,
                                       input rnd_mode_t mode,
                                       input logic      lsb,
                                       input logic      g,
                                       input logic      r,
                                       input logic      st);
    logic nx;
    nx = g | r | st;
    case (mode)
      RND_RNE: return g & (r | st | lsb);
      RND_RTZ: return 1'b0;
      RND_RDN: return s & nx;
      RND_RUP: return ~s & nx;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lamp_fpu_tay_res_fifo.sv
// Synchronous DEPTH x 16 result FIFO.
//   clk, rst           : clock, synchronous active-high reset
//   push_i, data_i     : write request and data; ignored when full unless
//                        a pop happens in the same cycle
//   pop_i              : read request; ignored when empty
//   data_o             : head entry (register contents, not a bypass)
//   full_o, empty_o    : status
//   count_o            : occupancy 0..DEPTH
module lamp_fpu_tay_res_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [15:0]                data_i,
  output logic [15:0]                data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // accept a write when it is also being read.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lamp_fpu_tay_rnd_out.sv
// Rounding, packing and output buffering for the bfloat16 Taylor multiplier.
//   valid_i, s/e/f_res_i, is*_i, rndMode_i : unrounded multiplier result
//   ready_o                                : credit, room for one more issue
//   result_o, valid_o, ready_i             : FIFO head toward the consumer
//   flags_o, flagsClr_i                    : sticky {DROP, OF, UF, NX}
module lamp_fpu_tay_rnd_out
  import taylor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        s_res_i,
  input  logic [7:0]  e_res_i,
  input  logic [11:0] f_res_i,
  input  logic        isOverflow_i,
  input  logic        isUnderflow_i,
  input  logic        isToRound_i,
  input  logic [1:0]  rndMode_i,
  output logic        ready_o,
  output logic [15:0] result_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  flags_o,
  input  logic        flagsClr_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  rnd_mode_t        mode;
  logic             nx_raw, inc, ovf, away;
  logic [8:0]       mant_in, mant_sum, e_sum;
  logic [6:0]       frac_rnd;
  logic [15:0]      res_c;
  logic [2:0]       flg_c;

  logic             stage_valid_q, stage_valid_d;
  logic [15:0]      stage_res_q, stage_res_d;
  logic [2:0]       stage_flg_q, stage_flg_d;   // {OF, UF, NX}
  logic [3:0]       flags_q, flags_d;

  logic             fifo_full, fifo_empty, fifo_pop, drop;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_sum;

  always_comb begin
    mode   = rnd_mode_t'(rndMode_i);
    nx_raw = |f_res_i[2:0];
    inc    = FUNC_rndInc(s_res_i, mode, f_res_i[3], f_res_i[2], f_res_i[1], f_res_i[0]);
    // f[11] is a producer-side overflow bit that a conforming multiplier
    // never sets; it is masked out of the mantissa.
    mant_in  = {f_res_i[11] & 1'b0, f_res_i[10:3]};
    mant_sum = mant_in + {8'd0, inc};
    e_sum    = {1'b0, e_res_i};
    frac_rnd = mant_sum[6:0];
    if (mant_sum[8]) begin
      e_sum    = e_sum + 9'd1;
      frac_rnd = '0;
    end else if ((e_res_i == 8'd0) && mant_sum[7]) begin
      // subnormal rounded up into the smallest normal
      e_sum = 9'd1;
    end
    ovf  = isOverflow_i | (e_sum >= 9'd255);
    away = (mode == RND_RNE) | ((mode == RND_RUP) & ~s_res_i) | ((mode == RND_RDN) & s_res_i);

    res_c = {s_res_i, e_res_i, f_res_i[9:3]};
    flg_c = '0;
    if (isToRound_i || isOverflow_i) begin
      if (ovf) begin
        res_c = (away ? PLUS_INF_BF16 : MAX_FIN_BF16) | {s_res_i, 15'd0};
        flg_c = 3'b101;
      end else begin
        res_c = {s_res_i, e_sum[7:0], frac_rnd};
        flg_c = {1'b0, isUnderflow_i & nx_raw, nx_raw};
      end
    end

    stage_valid_d = valid_i;
    stage_res_d   = valid_i ? res_c : stage_res_q;
    stage_flg_d   = valid_i ? flg_c : stage_flg_q;
  end

  lamp_fpu_tay_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (stage_valid_q),
    .pop_i   (fifo_pop),
    .data_i  (stage_res_q),
    .data_o  (result_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign valid_o  = ~fifo_empty;
  assign fifo_pop = valid_o & ready_i;
  assign drop     = stage_valid_q & fifo_full & ~fifo_pop;

  // Count every result already committed to the pipe so nothing issued
  // while ready_o is high can ever be dropped.
  assign credit_sum = {1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid_q}
                    + {{CNT_W{1'b0}}, valid_i};
  assign ready_o    = credit_sum < (CNT_W + 1)'(DEPTH);

  always_comb begin
    flags_d = flags_q & ~{4{flagsClr_i}};
    if (stage_valid_q) begin
      flags_d[FLAG_NX]   = flags_d[FLAG_NX] | stage_flg_q[0];
      flags_d[FLAG_UF]   = flags_d[FLAG_UF] | stage_flg_q[1];
      flags_d[FLAG_OF]   = flags_d[FLAG_OF] | stage_flg_q[2];
      flags_d[FLAG_DROP] = flags_d[FLAG_DROP] | drop;
    end
  end

  assign flags_o = flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_res_q   <= '0;
      stage_flg_q   <= '0;
      flags_q       <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_res_q   <= stage_res_d;
      stage_flg_q   <= stage_flg_d;
      flags_q       <= flags_d;
    end
  end

endmodule
